// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue and its FIFO.
package fetch_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_W    = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [PC_W-1:0]    PC_STEP   = 32'd4;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_HALT
    } fetch_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } fetch_entry_t;

    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] pc);
        return pc & ~PC_W'(3);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched {instr, pc} entries with a registered head that holds
// its last value while the buffer is empty.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             push_i,
    input  fetch_entry_t     wdata_i,
    input  logic             pop_i,
    output fetch_entry_t     head_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    fetch_entry_t     r_mem [DEPTH];
    fetch_entry_t     r_head;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_push;
    logic             w_pop;
    logic [PTR_W-1:0] w_rd_ptr_nxt;

    assign w_push       = push_i && !clear_i;
    assign w_pop        = pop_i && !clear_i && (r_count != '0);
    assign w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);

    // NOTE: storage is never read before it is written, so it carries no reset.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wdata_i;
        end
    end

    // NOTE: all state updates use <= so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Head follows the entry that will be at the front after this edge; held when empty.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_head <= '0;
        end else if (w_push && ((r_count == '0) || (w_pop && (r_count == CNT_W'(1))))) begin
            r_head <= wdata_i;
        end else if (w_pop && (r_count > CNT_W'(1))) begin
            r_head <= r_mem[w_rd_ptr_nxt];
        end
    end

    assign head_o  = r_head;
    assign count_o = r_count;

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: issues word fetches to imem, queues {instr, pc} for decode, flushes on redirect.
// Defining FETCH_STATS_EN adds the fetch_cnt_o / flush_cnt_o statistics counters.
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = INSTR_W,
    parameter int unsigned           ADDR_WIDTH = PC_W,
    parameter int unsigned           DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    output logic                  imem_req_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_gnt_i,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic [ADDR_WIDTH-1:0] pc_plus4_o,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    input  logic                  halt_i
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]           fetch_cnt_o,
    output logic [31:0]           flush_cnt_o
`endif
);

    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
    localparam int unsigned CRED_W = CNT_W + 1;

    fetch_state_e          r_state;
    fetch_state_e          w_state_next;
    logic [ADDR_WIDTH-1:0] r_fetch_pc;
    logic [ADDR_WIDTH-1:0] r_inflight_pc;
    logic                  r_inflight;

    logic                  w_req;
    logic                  w_accept;
    logic                  w_push;
    logic                  w_pop;
    logic [CNT_W-1:0]      w_count;
    logic [CRED_W-1:0]     w_credit;
    fetch_entry_t          w_wdata;
    fetch_entry_t          w_head;

    // Credit counts the outstanding response but not a same-cycle pop.
    assign w_credit = {1'b0, w_count} + CRED_W'(r_inflight);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: defaults first, so no path leaves an output unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_req        = 1'b0;
        unique case (r_state)
            S_BOOT: w_state_next = S_RUN;
            S_RUN: begin
                w_req = !redirect_i && (w_credit < CRED_W'(DEPTH));
                if (halt_i) begin
                    w_state_next = S_HALT;
                end
            end
            S_HALT: begin
                if (redirect_i && !halt_i) begin
                    w_state_next = S_RUN;
                end
            end
            default: w_state_next = S_BOOT;
        endcase
    end

    assign w_accept = w_req && imem_gnt_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else begin
            if (redirect_i) begin
                r_fetch_pc <= word_align(redirect_pc_i);
            end else if (w_accept) begin
                r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(PC_STEP);
            end
            r_inflight <= w_accept;
            if (w_accept) begin
                r_inflight_pc <= r_fetch_pc;
            end
        end
    end

    // A redirect discards both the queue and the response arriving this cycle.
    assign w_push  = r_inflight && !redirect_i;
    assign w_pop   = instr_valid_o && instr_ready_i && !redirect_i;
    assign w_wdata = '{instr: imem_rdata_i, pc: r_inflight_pc};

    fetch_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (redirect_i),
        .push_i  (w_push),
        .wdata_i (w_wdata),
        .pop_i   (w_pop),
        .head_o  (w_head),
        .count_o (w_count)
    );

    assign imem_req_o    = w_req;
    assign imem_addr_o   = r_fetch_pc;
    assign instr_valid_o = (w_count != '0);
    assign instr_o       = w_head.instr;
    assign pc_o          = w_head.pc;
    assign pc_plus4_o    = w_head.pc + ADDR_WIDTH'(PC_STEP);

`ifdef FETCH_STATS_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_fetch_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_pop) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (redirect_i) begin
                r_flush_cnt <= r_flush_cnt + 32'(w_count) + 32'(r_inflight);
            end
        end
    end

    assign fetch_cnt_o = r_fetch_cnt;
    assign flush_cnt_o = r_flush_cnt;
`endif

endmodule
